// File: rtl/toilet_pkg.sv
// toilet_pkg: debouncer state encoding, default timing constants and input channel indices
// shared by the toilet input conditioner.
package toilet_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } db_state_e;

    localparam int CE_PERIOD_DEF       = 1_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = 10_000;

    localparam int CH_USER        = 0;
    localparam int CH_SEAT        = 1;
    localparam int CH_SPRAY       = 2;
    localparam int CH_SP_DR_AUTO  = 3;
    localparam int CH_SPRAY_MODE  = 4;
    localparam int CH_AUTO_DIS    = 5;
    localparam int CH_DE_UR       = 6;
    localparam int N_CH           = 7;

endpackage

// File: rtl/input_debounce.sv
// input_debounce: one raw input channel, 2-flop synchroniser followed by a debounce FSM.
// The FSM is built only with TOILET_IN_DEBOUNCE_EN; otherwise the synchroniser drives level directly.
module input_debounce
    import toilet_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    logic [1:0] sync_q, sync_d;
    logic       s;

    always_comb begin
        sync_d = {sync_q[0], raw};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign s = sync_q[1];

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
    end

`ifdef TOILET_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    db_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The edge on which the counter reaches its last value is the final WAIT edge.
    always_comb begin
        cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LO: if (s) begin
                state_d = WAIT_HI;
                cnt_d   = '0;
            end
            WAIT_HI: if (!s) state_d = STABLE_LO;
            else begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == CNT_LAST) ? STABLE_HI : WAIT_HI;
            end
            STABLE_HI: if (!s) begin
                state_d = WAIT_LO;
                cnt_d   = '0;
            end
            WAIT_LO: if (s) state_d = STABLE_HI;
            else begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == CNT_LAST) ? STABLE_LO : WAIT_LO;
            end
            default: state_d = STABLE_LO;
        endcase
    end

    always_comb begin
        level = (state_q == STABLE_HI) || (state_q == WAIT_LO);
    end
`else
    always_comb begin
        level = s;
    end
`endif

endmodule

// File: rtl/toilet_input_conditioner.sv
// toilet_input_conditioner: conditions panel buttons and sensors into controller request/mode
// levels and pulses, and generates the ce time-base tick. Debounce enabled by TOILET_IN_DEBOUNCE_EN.
module toilet_input_conditioner
    import toilet_pkg::*;
#(
    parameter int CE_PERIOD       = CE_PERIOD_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_user,
    input  logic raw_seat,
    input  logic raw_spray_btn,
    input  logic raw_sp_dr_auto,
    input  logic raw_spray_mode,
    input  logic raw_auto_dis,
    input  logic raw_de_ur,
    input  logic stt_ready,
    output logic reg_user_en,
    output logic reg_toilet_using,
    output logic reg_spray_en,
    output logic reg_sp_dr_auto_en,
    output logic reg_spray_mode,
    output logic reg_auto_dis_en,
    output logic reg_de_ur,
    output logic ce
);

    localparam int CEW = $clog2(CE_PERIOD);
    localparam logic [CEW-1:0] CE_LAST = CEW'(CE_PERIOD - 1);

    logic [N_CH-1:0] raw_vec, lvl;

    assign raw_vec = {raw_de_ur, raw_auto_dis, raw_spray_mode, raw_sp_dr_auto,
                      raw_spray_btn, raw_seat, raw_user};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_vec[i]),
            .level(lvl[i])
        );
    end

    logic           user_q, user_d;
    logic           seat_q, seat_d;
    logic           spray_prev_q, spray_prev_d;
    logic           spray_q, spray_d;
    logic [3:0]     mode_q, mode_d;
    logic [CEW-1:0] ce_cnt_q, ce_cnt_d;
    logic           ce_q, ce_d;

    // Modes are frozen while the controller is busy.
    always_comb begin
        user_d       = lvl[CH_USER];
        seat_d       = lvl[CH_SEAT];
        spray_prev_d = lvl[CH_SPRAY];
        spray_d      = lvl[CH_SPRAY] & ~spray_prev_q;
        mode_d       = stt_ready ? lvl[CH_DE_UR:CH_SP_DR_AUTO] : mode_q;
        ce_cnt_d     = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + CEW'(1);
        ce_d         = (ce_cnt_d == CE_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            user_q       <= 1'b0;
            seat_q       <= 1'b0;
            spray_prev_q <= 1'b0;
            spray_q      <= 1'b0;
            mode_q       <= '0;
            ce_cnt_q     <= '0;
            ce_q         <= 1'b0;
        end else begin
            user_q       <= user_d;
            seat_q       <= seat_d;
            spray_prev_q <= spray_prev_d;
            spray_q      <= spray_d;
            mode_q       <= mode_d;
            ce_cnt_q     <= ce_cnt_d;
            ce_q         <= ce_d;
        end
    end

    assign reg_user_en       = user_q;
    assign reg_toilet_using  = seat_q;
    assign reg_spray_en      = spray_q;
    assign reg_sp_dr_auto_en = mode_q[0];
    assign reg_spray_mode    = mode_q[1];
    assign reg_auto_dis_en   = mode_q[2];
    assign reg_de_ur         = mode_q[3];
    assign ce                = ce_q;

endmodule

// File: tb/tb_toilet_input_conditioner.sv
// tb_toilet_input_conditioner: directed checks of ce timing, debounce latency, glitch rejection,
// spray pulse, mode gating and asynchronous reset; latencies follow TOILET_IN_DEBOUNCE_EN.
module tb_toilet_input_conditioner;

    localparam int CEP = 10;
    localparam int DB  = 4;
`ifdef TOILET_IN_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_user = 0, raw_seat = 0, raw_spray_btn = 0, raw_sp_dr_auto = 0;
    logic raw_spray_mode = 0, raw_auto_dis = 0, raw_de_ur = 0, stt_ready = 0;
    logic reg_user_en, reg_toilet_using, reg_spray_en, reg_sp_dr_auto_en;
    logic reg_spray_mode, reg_auto_dis_en, reg_de_ur, ce;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    toilet_input_conditioner #(
        .CE_PERIOD(CEP),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_user(raw_user),
        .raw_seat(raw_seat),
        .raw_spray_btn(raw_spray_btn),
        .raw_sp_dr_auto(raw_sp_dr_auto),
        .raw_spray_mode(raw_spray_mode),
        .raw_auto_dis(raw_auto_dis),
        .raw_de_ur(raw_de_ur),
        .stt_ready(stt_ready),
        .reg_user_en(reg_user_en),
        .reg_toilet_using(reg_toilet_using),
        .reg_spray_en(reg_spray_en),
        .reg_sp_dr_auto_en(reg_sp_dr_auto_en),
        .reg_spray_mode(reg_spray_mode),
        .reg_auto_dis_en(reg_auto_dis_en),
        .reg_de_ur(reg_de_ur),
        .ce(ce)
    );

    wire [7:0] outs = {reg_user_en, reg_toilet_using, reg_spray_en, reg_sp_dr_auto_en,
                       reg_spray_mode, reg_auto_dis_en, reg_de_ur, ce};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int pulses;
        int first;
        @(negedge clk);
        step(2);
        chk("reset_outs", 32'(outs), 32'h0);
        reset = 1'b0;

        // ce expected just before edge k
        for (int k = 1; k <= 35; k++) begin
            chk("ce", 32'(ce), 32'(k % CEP == 0));
            step(1);
        end

        raw_seat = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 3) raw_seat = 1'b0;
`ifdef TOILET_IN_DEBOUNCE_EN
            chk("seat_glitch", 32'(reg_toilet_using), 32'h0);
`else
            chk("seat_glitch", 32'(reg_toilet_using), 32'(k >= 3 && k <= 5));
`endif
        end

        raw_seat = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            step(1);
            chk("seat_rise", 32'(reg_toilet_using), 32'(k >= LAT));
        end
        raw_seat = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            step(1);
            chk("seat_fall", 32'(reg_toilet_using), 32'(k < LAT));
        end

        raw_spray_btn = 1'b1;
        pulses = 0;
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (k == 20) raw_spray_btn = 1'b0;
            if (reg_spray_en) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        chk("spray_pulses", 32'(pulses), 32'd1);
        chk("spray_edge", 32'(first), 32'(LAT));

        raw_auto_dis = 1'b1;
        step(LAT + 3);
        chk("mode_busy", 32'(reg_auto_dis_en), 32'h0);
        stt_ready = 1'b1;
        step(1);
        chk("mode_load", 32'(reg_auto_dis_en), 32'h1);
        chk("mode_other", 32'(reg_sp_dr_auto_en), 32'h0);
        stt_ready = 1'b0;
        raw_auto_dis = 1'b0;
        step(LAT + 3);
        chk("mode_freeze", 32'(reg_auto_dis_en), 32'h1);

        stt_ready = 1'b1;
        raw_de_ur = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            chk("de_ur_settle", 32'(reg_de_ur), 32'(k >= LAT));
        end
        chk("auto_dis_reload", 32'(reg_auto_dis_en), 32'h0);
        stt_ready = 1'b0;

        raw_seat = 1'b1;
        step(LAT + 2);
        chk("seat_pre_reset", 32'(reg_toilet_using), 32'h1);
        raw_user = 1'b1;
        step(5);
        reset = 1'b1;
        #1;
        chk("reset_async", 32'(outs), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            step(1);
            chk("user_requal", 32'(reg_user_en), 32'(k >= LAT));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toilet_input_conditioner.md
# toilet_input_conditioner

Front-end stage directly upstream of the toilet controller FSM. Synchronises and debounces the raw panel buttons and seat/presence sensors, and turns them into the `reg_*` request/mode levels and pulses the controller consumes. Also generates the `ce` time-base tick that drives the controller's spray, drying and discharge counters. Mode settings are frozen while the controller is busy, so they only change while it reports ready.

## Interface
Parameters:
- `CE_PERIOD`, 1_000_000: clock cycles per `ce` pulse (1 s at 1 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, 10_000: consecutive stable cycles needed to accept an input change (10 ms); must be ≥ 2.

Ports:
- `clk`  in  1  system clock, 1 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `raw_user`  in  1  user presence sensor, asynchronous.
- `raw_seat`  in  1  seat occupancy sensor, asynchronous.
- `raw_spray_btn`  in  1  spray/finish push button, asynchronous.
- `raw_sp_dr_auto`  in  1  auto spray+dry mode switch.
- `raw_spray_mode`  in  1  spray pattern switch.
- `raw_auto_dis`  in  1  auto discharge enable switch.
- `raw_de_ur`  in  1  discharge type switch (1 = urine / short, 0 = full).
- `stt_ready`  in  1  controller idle status; gates mode latching.
- `reg_user_en`  out  1  debounced presence, level.
- `reg_toilet_using`  out  1  debounced seat occupancy, level.
- `reg_spray_en`  out  1  one-cycle pulse on the debounced spray button press.
- `reg_sp_dr_auto_en`, `reg_spray_mode`, `reg_auto_dis_en`, `reg_de_ur`  out  1 each  latched mode levels.
- `ce`  out  1  one-cycle time-base tick.

## Operation
- Each of the 7 raw inputs passes through a 2-flop synchroniser and then a per-channel debouncer.
- Debouncer FSM states and transitions:
  - STABLE_LO: the synchronised input `s` is 1 → WAIT_HI, with the counter cleared.
  - WAIT_HI: `s` = 0 → STABLE_LO (glitch rejected). Otherwise the counter increments each cycle. At `DEBOUNCE_CYCLES-1` → STABLE_HI.
  - STABLE_HI and WAIT_LO: mirror images of STABLE_LO and WAIT_HI.
- The debounced level is 1 in STABLE_HI and WAIT_LO.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter saturates and never wraps.
- `reg_user_en` and `reg_toilet_using` are registered copies of their debounced levels.
- `reg_spray_en` is registered as (debounced spray & ~previous debounced spray).
  - Exactly one cycle per accepted press.
  - Nothing on release.
  - Holding the button produces no further pulses.
- Mode outputs (`reg_sp_dr_auto_en`, `reg_spray_mode`, `reg_auto_dis_en`, `reg_de_ur`):
  - Load their debounced value on every edge where `stt_ready` = 1.
  - Hold their value while `stt_ready` = 0.
  - A switch moved mid-cycle takes effect on the first edge with `stt_ready` = 1.
- `ce` counter:
  - Free-running, `$clog2(CE_PERIOD)` bits, counting 0..`CE_PERIOD-1` and then wrapping to 0.
  - `ce` = 1 for the single cycle in which the counter equals `CE_PERIOD-1`.

## Timing
- Reset (asynchronous, active-high):
  - All outputs are 0.
  - Synchroniser flops are 0.
  - Debouncers are in STABLE_LO with counter 0.
  - The `ce` counter is 0.
- After reset deassertion, the first `ce` occurs on the `CE_PERIOD`-th rising edge.
- With debounce compiled in, a raw change held stable appears on the `reg_*` level outputs at edge 3 + `DEBOUNCE_CYCLES` after the change:
  - 2 edges for the synchroniser.
  - `DEBOUNCE_CYCLES` edges in WAIT.
  - 1 edge for the output register.
- `reg_spray_en` has the same latency as the level outputs.
- Glitch rejection: any excursion shorter than `DEBOUNCE_CYCLES` synchronised cycles is ignored, and the counter restarts from 0 on the next change.
- Reset during WAIT_* returns the channel to STABLE_LO. An input still held high is then re-qualified from scratch.
- Simultaneous events are independent per channel. A mode output whose debounced value settles on the same edge that `stt_ready` rises loads the new value.

## Configuration
- Macro `TOILET_IN_DEBOUNCE_EN`.
- Defined: the debouncers are instantiated as described above.
- Undefined:
  - Synchroniser outputs feed the output stage directly, with latency 3 edges.
  - `DEBOUNCE_CYCLES` is ignored.
  - Used for fast simulation.
- Synchroniser, `ce` generator and mode gating are identical in both builds.

## Structure
- Shared package `toilet_pkg` holds:
  - Debouncer state encoding: STABLE_LO = 2'b00, WAIT_HI = 2'b01, STABLE_HI = 2'b10, WAIT_LO = 2'b11.
  - Default `CE_PERIOD` and `DEBOUNCE_CYCLES` constants.
  - Input channel index constants.
- Sub-module `input_debounce` contains one channel:
  - Synchroniser, FSM and counter.
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports `clk`, `reset`, `raw`, `level`.
  - Instantiated 7 times.

## Test plan
Run with `CE_PERIOD` = 10 and `DEBOUNCE_CYCLES` = 4 unless noted.
- Release reset, let the bench run 35 cycles → `ce` pulses on edges 10, 20, 30, each 1 cycle wide.
- `raw_seat` high for 3 cycles, then low → `reg_toilet_using` stays 0 throughout.
- `raw_seat` rises and holds → `reg_toilet_using` rises on edge 7 after the change; falls 7 edges after `raw_seat` drops.
- `raw_spray_btn` held high for 20 cycles → exactly one `reg_spray_en` pulse, 7 edges after the press.
- `stt_ready` = 0, then toggle `raw_auto_dis` to 1 → `reg_auto_dis_en` stays 0. Raise `stt_ready` → 1 on the next edge.
- Assert `reset` 2 cycles into WAIT_HI with `raw_user` still high:
  - All outputs drop to 0 asynchronously.
  - After release, `reg_user_en` rises 7 edges later.
  - Repeat the same stimulus with `TOILET_IN_DEBOUNCE_EN` undefined → rise after 3 edges.
